// File: rtl/vec_mem_sequencer.sv
// Splits one LDV/STV into LANES element accesses (base+4*lane); done pulses one cycle after the last lane.
// Waits on mem_gnt/mem_rvalid; `VEC_MEM_TIMEOUT_EN` adds an abort after TIMEOUT idle cycles (err=1).
module vec_mem_sequencer #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*DATA_W-1:0] req_wdata,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] rdata,
    output logic                    err
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                    state_q;
    logic [LW-1:0]             lane_q;
    logic                      we_q;
    logic [ADDR_W-1:0]         base_q;
    logic [LANES*DATA_W-1:0]   wdata_q;
    logic [LANES*DATA_W-1:0]   rdata_q;
    logic                      mem_req_q;
    logic                      mem_we_q;
    logic [ADDR_W-1:0]         mem_addr_q;
    logic [DATA_W-1:0]         mem_wdata_q;
    logic                      done_q;
    logic                      err_q;

    logic                      in_issue;
    logic                      in_wait;
    logic                      capture;
    logic                      advance;
    logic                      progress;
    logic                      tmo_hit;
    logic [LW-1:0]             lane_nxt;

    assign in_issue = (state_q == S_ISSUE);
    assign in_wait  = (state_q == S_WAIT);
    // A load granted with its data in the same cycle skips WAIT entirely.
    assign capture  = (in_issue && mem_gnt && !we_q && mem_rvalid) || (in_wait && mem_rvalid);
    assign advance  = (in_issue && mem_gnt && we_q) || capture;
    assign progress = (in_issue && mem_gnt) || (in_wait && mem_rvalid);
    assign lane_nxt = lane_q + LW'(1);

`ifdef VEC_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (in_issue || in_wait) && !progress && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (!(in_issue || in_wait) || progress) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT > 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_write;
                        base_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        lane_q      <= '0;
                        state_q     <= S_ISSUE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= req_write;
                        mem_addr_q  <= req_addr;
                        mem_wdata_q <= req_wdata[DATA_W-1:0];
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (capture) begin
                        rdata_q[int'(lane_q)*DATA_W +: DATA_W] <= mem_rdata;
                    end
                    if (tmo_hit || (advance && lane_q == LAST)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= tmo_hit;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else if (advance) begin
                        lane_q      <= lane_nxt;
                        state_q     <= S_ISSUE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= we_q;
                        mem_addr_q  <= base_q + (ADDR_W'(lane_nxt) << 2);
                        mem_wdata_q <= wdata_q[int'(lane_nxt)*DATA_W +: DATA_W];
                    end else if (in_issue && mem_gnt) begin
                        state_q   <= S_WAIT;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = (state_q == S_IDLE && req_valid) || in_issue || in_wait;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: the bench acts as the memory and predicts addresses, data and rdata per access.
module tb_vec_mem_sequencer;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         done;
    logic [127:0] rdata;
    logic         err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] exp_rdata;

    vec_mem_sequencer #(
        .LANES(4), .DATA_W(32), .ADDR_W(32), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .done(done), .rdata(rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic int pick_g(input int l, input int hl, input int hn, input int gm);
        return (l == hl) ? hn : int'($urandom_range(gm, 0));
    endfunction

    // One vector access; the bench plays memory with per-lane grant delay and read latency.
    task automatic vec_op(input string tag, input bit wr, input logic [31:0] base,
                          input logic [127:0] wd, input logic [127:0] rd,
                          input int gmax, input int lmin, input int lmax,
                          input int hold_lane, input int hold_n,
                          input int abort_lane, input int exp_cyc);
        int lane, gwait, rcnt, lat;
        bit pend, fin;
        logic [127:0] exp_vec;
        logic [31:0] ea;
        lane = 0; pend = 0; fin = 0; rcnt = 0;
        gwait = pick_g(0, hold_lane, hold_n, gmax);
        exp_vec = wr ? exp_rdata : rd;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = base; req_wdata = wd;
        #1 chk({tag, "/stall_accept"}, 128'(stall), 128'd1);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (done) begin
                chk({tag, "/lanes_done"}, 128'(lane), 128'd4);
                chk({tag, "/rdata"}, rdata, exp_vec);
                chk({tag, "/err"}, 128'(err), 128'd0);
                chk({tag, "/stall_done"}, 128'(stall), 128'd0);
                if (exp_cyc >= 0) chk({tag, "/done_cycle"}, 128'(cyc), 128'(exp_cyc));
                req_valid = 1'b0;
                exp_rdata = exp_vec;
                fin = 1'b1;
            end else begin
                chk({tag, "/stall_busy"}, 128'(stall), 128'd1);
                if (pend) begin
                    chk({tag, "/req_in_wait"}, 128'(mem_req), 128'd0);
                    if (lane == abort_lane) begin
                        rst = 1'b1; req_valid = 1'b0;
                        #1;
                        chk({tag, "/rst_req"}, 128'(mem_req), 128'd0);
                        chk({tag, "/rst_rdata"}, rdata, 128'd0);
                        chk({tag, "/rst_done"}, 128'(done), 128'd0);
                        chk({tag, "/rst_stall"}, 128'(stall), 128'd0);
                        @(negedge clk);
                        chk({tag, "/rst_done2"}, 128'(done), 128'd0);
                        rst = 1'b0;
                        exp_rdata = '0;
                        return;
                    end
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rd[lane*32 +: 32];
                        lane++; pend = 1'b0;
                        gwait = pick_g(lane, hold_lane, hold_n, gmax);
                    end else begin
                        rcnt--;
                    end
                end else if (mem_req) begin
                    chk({tag, "/no_extra_req"}, 128'(lane < 4), 128'd1);
                    ea = base + 32'(lane * 4);
                    chk({tag, "/addr"}, 128'(mem_addr), 128'(ea));
                    chk({tag, "/we"}, 128'(mem_we), 128'(wr));
                    if (wr) chk({tag, "/wdata"}, 128'(mem_wdata), 128'(wd[lane*32 +: 32]));
                    if (gwait > 0) begin
                        gwait--;
                    end else begin
                        mem_gnt = 1'b1;
                        lat = int'($urandom_range(lmax, lmin));
                        if (wr || lat == 0) begin
                            if (!wr) begin mem_rvalid = 1'b1; mem_rdata = rd[lane*32 +: 32]; end
                            lane++;
                            gwait = pick_g(lane, hold_lane, hold_n, gmax);
                        end else begin
                            pend = 1'b1; rcnt = lat - 1;
                        end
                    end
                end
            end
        end
        if (!fin) begin
            chk({tag, "/done_timeout"}, 128'(fin), 128'd1);
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            rst = 1'b1; @(negedge clk); rst = 1'b0; exp_rdata = '0;
        end else begin
            @(negedge clk);
            chk({tag, "/done_pulse_end"}, 128'(done), 128'd0);
            chk({tag, "/idle_req"}, 128'(mem_req), 128'd0);
            chk({tag, "/idle_stall"}, 128'(stall), 128'd0);
        end
    endtask

    initial begin
        logic [127:0] rv, wv;
        logic [31:0]  b;
        bit           w;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset/mem_req", 128'(mem_req), 128'd0);
        chk("reset/mem_we", 128'(mem_we), 128'd0);
        chk("reset/mem_addr", 128'(mem_addr), 128'd0);
        chk("reset/mem_wdata", 128'(mem_wdata), 128'd0);
        chk("reset/done", 128'(done), 128'd0);
        chk("reset/err", 128'(err), 128'd0);
        chk("reset/rdata", rdata, 128'd0);
        chk("reset/stall", 128'(stall), 128'd0);
        rst = 1'b0;

        vec_op("ldv_lat2", 1'b0, 32'h100, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
               0, 2, 2, -1, 0, -1, -1);
        vec_op("stv_hold", 1'b1, 32'h200, {32'd4, 32'd3, 32'd2, 32'd1}, '0,
               0, 0, 0, 1, 3, -1, -1);
        rv = {$urandom, $urandom, $urandom, $urandom};
        vec_op("ldv_wrap", 1'b0, 32'hFFFF_FFF8, '0, rv, 0, 0, 0, -1, 0, -1, 4);

        for (int i = 0; i < 10; i++) begin
            w  = 1'($urandom_range(1, 0));
            b  = (i % 3 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0)) : $urandom;
            rv = {$urandom, $urandom, $urandom, $urandom};
            wv = {$urandom, $urandom, $urandom, $urandom};
            vec_op("random", w, b, wv, rv, 3, 0, 3, -1, 0, -1, -1);
        end

        rv = {$urandom, $urandom, $urandom, $urandom};
        vec_op("rst_wait", 1'b0, 32'h300, '0, rv, 0, 3, 3, -1, 0, 2, -1);
        rv = {$urandom, $urandom, $urandom, $urandom};
        vec_op("after_rst", 1'b0, 32'h400, '0, rv, 1, 0, 2, -1, 0, -1, -1);

        // Memory never grants: either the abort fires or the front end stays frozen.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500;
`ifdef VEC_MEM_TIMEOUT_EN
        begin
            int dcyc;
            dcyc = -1;
            for (int cyc = 0; cyc < 40 && dcyc < 0; cyc++) begin
                @(negedge clk);
                if (done) begin
                    dcyc = cyc;
                    chk("timeout/err", 128'(err), 128'd1);
                    req_valid = 1'b0;
                end
            end
            chk("timeout/done_cycle", 128'(dcyc), 128'd16);
        end
`else
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            chk("no_timeout/stall_done", 128'({stall, done, err}), 128'b100);
        end
`endif
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("final_reset/stall", 128'(stall), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
